parity_stream: RTL and testbench
================================

Name: parity_stream

Overview:
- Streaming parity generator/checker; successor to the fixed 8-bit combinational parity block.
- Accumulates parity over a multi-word frame of WIDTH-bit words on a valid/ready input stream.
- Emits one registered result per frame on a valid/ready output: parity bit, optional check error, word count and overflow flag.
- Sits between a byte/word source (UART RX, bus capture) and the frame consumer.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_WORDS, 16, maximum words per frame (>=1); frame is force-closed at this length.
- CW, $clog2(MAX_WORDS+1), derived width of the count field (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_last  in  1  word is the last of its frame.
- mode  in  1  0 = even parity, 1 = odd parity; sampled on the first word of a frame.
- chk_en  in  1  enables checking; sampled on the first word of a frame.
- chk_bit  in  1  received parity bit; sampled on the word that closes the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_parity  out  1  generated parity bit.
- out_err  out  1  chk_en && (chk_bit != out_parity).
- out_count  out  CW  words in the frame (1..MAX_WORDS).
- out_overflow  out  1  frame closed by the MAX_WORDS limit, not by in_last.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_parity = 0, out_err = 0, out_count = 0, out_overflow = 0
  - internal accumulator = 0, counter = 0, latched mode = 0, latched chk_en = 0
- Accept rule: a word is accepted when in_valid && in_ready on a rising clk edge.
- in_ready = (state != RESULT), driven from a registered state only.
- Word parity: wp = XOR reduction of in_data.
- States and transitions:
  - IDLE: on accept, latch mode and chk_en, acc <= wp, cnt <= 1.
    - If the frame closes on this word -> RESULT; else -> ACCUM.
  - ACCUM: on accept, acc <= acc ^ wp, cnt <= cnt + 1.
    - If the frame closes -> RESULT; else stay in ACCUM.
  - RESULT: out_valid = 1. On out_valid && out_ready -> IDLE.
- Frame close condition: in_last, OR the accepted word is word number MAX_WORDS (cnt == MAX_WORDS-1 before the accept).
- MAX_WORDS = 1: every word closes its frame.
- Result computed at close:
  - final = acc ^ wp
  - out_parity = final ^ mode (even: total ones in data+parity is even; odd: total is odd)
  - out_err = chk_en_latched && (chk_bit != out_parity)
  - out_count = cnt + 1
  - out_overflow = !in_last
  - If in_last is high on exactly word MAX_WORDS: out_overflow = 0.
- Result fields are registered. out_valid rises the cycle after the closing word is accepted (latency 1).
- Result fields stay stable while out_valid && !out_ready.
- No bypass: in_ready returns high the cycle after the result handshake. Minimum frame period is 2 cycles for a 1-word frame.
- After an overflow close, the next accepted word starts a new frame and re-samples mode and chk_en.
- mode/chk_en changes mid-frame are ignored. chk_bit is ignored on non-closing words.
- Reset mid-frame or mid-RESULT: the partial frame and any pending result are discarded; no out_valid pulse.
- Count arithmetic is unsigned CW bits; it cannot wrap because close forces cnt <= MAX_WORDS.

Decomposition:
- Package parity_pkg:
  - state typedef (IDLE, ACCUM, RESULT)
  - mode constants PAR_EVEN = 0, PAR_ODD = 1
  - function computing CW from MAX_WORDS
- One combinational sub-module word_parity (parameter WIDTH; in_data -> wp), reusable by other blocks.

Test Plan:
- Single frame, mode=0, in_data=8'hA5 with in_last=1 -> one cycle later out_valid=1, out_parity=0, out_count=1, out_overflow=0, out_err=0.
- Frame 8'h01, 8'h03, 8'h07 (6 ones), last on 3rd word:
  - mode=0 -> out_parity=0, out_count=3.
  - Repeat with mode=1 -> out_parity=1.
  - Toggling mode mid-frame does not change the result.
- Check mode, chk_en=1, mode=0, single word 8'h01:
  - chk_bit=1 -> out_parity=1, out_err=0.
  - chk_bit=0 -> out_err=1.
  - chk_en=0 with chk_bit=0 -> out_err=0.
- Overflow, MAX_WORDS=16: 17 words of 8'h03 with in_last=0 ->
  - result after the 16th word: out_count=16, out_parity=0, out_overflow=1.
  - the 17th word (sent with in_last=1) -> out_count=1, out_overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles with result pending ->
  - in_ready=0 and all out_* stable throughout.
  - After out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
- Asynchronous reset asserted between clk edges after 2 of 3 words -> out_valid and in_ready go to reset values immediately.
  - A new 1-word frame 8'hFF, mode=1 -> out_parity=1, out_count=1.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared types and helpers for the streaming parity blocks.
//   state_t  - frame FSM states (IDLE, ACCUM, RESULT)
//   PAR_EVEN / PAR_ODD - values of the mode input
//   calc_cw  - width of a word-count field able to hold 0..max_words
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int calc_cw(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/word_parity.sv
// word_parity: combinational XOR reduction of one data word.
//   in_data [WIDTH-1:0] - word to reduce
//   wp                  - 1 when in_data holds an odd number of ones
module word_parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_data,
    output logic             wp
);

    assign wp = ^in_data;

endmodule

// File: rtl/parity_stream.sv
// parity_stream: streaming parity generator/checker over multi-word frames.
// Words arrive on a valid/ready stream; one registered result per frame leaves
// on a valid/ready output.
//   clk, rst            - clock (rising edge), async active-high reset
//   in_valid/in_ready   - input handshake; in_ready low while a result waits
//   in_data, in_last    - word and end-of-frame marker
//   mode, chk_en        - even/odd select and check enable, taken from word 1
//   chk_bit             - received parity, taken from the closing word
//   out_valid/out_ready - result handshake
//   out_parity, out_err, out_count, out_overflow - frame result fields
module parity_stream
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = calc_cw(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    input  logic             chk_en,
    input  logic             chk_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    state_t        state, state_nxt;
    logic          acc, acc_nxt, acc_cur;
    logic [CW-1:0] cnt, cnt_nxt, cnt_cur;
    logic          mode_q, mode_nxt, chk_q, chk_nxt;
    logic          wp, accept, first, close, load_res;
    logic          eff_mode, eff_chk, res_parity;

    word_parity #(.WIDTH(WIDTH)) u_wp (
        .in_data (in_data),
        .wp      (wp)
    );

    // Both handshake outputs decode the registered state only.
    assign in_ready  = (state != RESULT);
    assign out_valid = (state == RESULT);

    always_comb begin
        accept   = in_valid && in_ready;
        // On the first word the accumulator/counter contents are stale, so
        // treat them as zero and take mode/chk_en straight from the inputs.
        first    = (state == IDLE);
        acc_cur  = first ? 1'b0 : acc;
        cnt_cur  = first ? '0 : cnt;
        eff_mode = first ? mode : mode_q;
        eff_chk  = first ? chk_en : chk_q;
        // Word number MAX_WORDS closes the frame even without in_last.
        close      = in_last || (cnt_cur == CW'(MAX_WORDS - 1));
        res_parity = acc_cur ^ wp ^ eff_mode;

        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        chk_nxt   = chk_q;
        load_res  = 1'b0;

        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_nxt  = acc_cur ^ wp;
                    cnt_nxt  = cnt_cur + CW'(1);
                    mode_nxt = eff_mode;
                    chk_nxt  = eff_chk;
                    if (close) begin
                        state_nxt = RESULT;
                        load_res  = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            RESULT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            chk_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            chk_q  <= chk_nxt;
        end
    end

    // Result fields load only at frame close, so they hold while the
    // consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity   <= 1'b0;
            out_err      <= 1'b0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (load_res) begin
            out_parity   <= res_parity;
            out_err      <= eff_chk && (chk_bit != res_parity);
            out_count    <= cnt_cur + CW'(1);
            out_overflow <= !in_last;
        end
    end

endmodule

// File: tb/tb_parity_stream.sv
module tb_parity_stream;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             mode = 1'b0;
    logic             chk_en = 1'b0;
    logic             chk_bit = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_parity;
    logic             out_err;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    parity_stream #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .mode         (mode),
        .chk_en       (chk_en),
        .chk_bit      (chk_bit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_parity   (out_parity),
        .out_err      (out_err),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       chk_en;
        logic       chk_bit;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one word at a negedge and return right after the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic l, input logic m,
                        input logic ce, input logic cb);
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        mode = m; chk_en = ce; chk_bit = cb;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    // Expects the result exactly one cycle after the closing word, then drains it.
    task automatic take(input string name, input logic ep, input logic ee,
                        input int ec, input logic eo);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_valid"},    {31'b0, out_valid},    32'd1);
        chk({name, "_parity"},   {31'b0, out_parity},   {31'b0, ep});
        chk({name, "_err"},      {31'b0, out_err},      {31'b0, ee});
        chk({name, "_count"},    32'(out_count),        32'(ec));
        chk({name, "_overflow"}, {31'b0, out_overflow}, {31'b0, eo});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drained"},  {31'b0, out_valid}, 32'd0);
        chk({name, "_ready"},    {31'b0, in_ready},  32'd1);
    endtask

    initial begin
        logic       s_par, s_err, s_ov;
        logic [CW-1:0] s_cnt;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset values
        #12;
        chk("rst_in_ready",  {31'b0, in_ready},     32'd1);
        chk("rst_out_valid", {31'b0, out_valid},    32'd0);
        chk("rst_parity",    {31'b0, out_parity},   32'd0);
        chk("rst_err",       {31'b0, out_err},      32'd0);
        chk("rst_count",     32'(out_count),        32'd0);
        chk("rst_overflow",  {31'b0, out_overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-word frames
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].data, 1'b1, tbl[i].mode, tbl[i].chk_en, tbl[i].chk_bit);
            take($sformatf("vec%0d", i), tbl[i].exp_par, tbl[i].exp_err, 1, 1'b0);
        end

        // Three-word frame, even then odd
        send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        take("f3_even", 1'b0, 1'b0, 3, 1'b0);
        send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        take("f3_odd", 1'b1, 1'b0, 3, 1'b0);

        // mode/chk_en toggled mid-frame ignored; chk_bit only from closing word
        send(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        take("f3_toggle", 1'b0, 1'b0, 3, 1'b0);

        // Overflow close after 16 words, then a fresh 1-word frame
        for (int i = 0; i < MAX_WORDS; i++) send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        take("ovf", 1'b0, 1'b0, 16, 1'b1);
        send(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        take("ovf_next", 1'b0, 1'b0, 1, 1'b0);

        // in_last exactly on word MAX_WORDS is not an overflow
        for (int i = 0; i < MAX_WORDS - 1; i++) send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        take("last_at_max", 1'b0, 1'b0, 16, 1'b0);

        // Backpressure: result held 5 cycles while a word is offered
        send(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_data = 8'h0F; in_last = 1'b1;
        s_par = out_parity; s_err = out_err; s_cnt = out_count; s_ov = out_overflow;
        chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_first_par",   {31'b0, out_parity}, 32'd1);
        chk("bp_first_err",   {31'b0, out_err},    32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  {31'b0, in_ready},     32'd0);
            chk("bp_valid",     {31'b0, out_valid},    32'd1);
            chk("bp_parity",    {31'b0, out_parity},   {31'b0, s_par});
            chk("bp_err",       {31'b0, out_err},      {31'b0, s_err});
            chk("bp_count",     32'(out_count),        32'(s_cnt));
            chk("bp_overflow",  {31'b0, out_overflow}, {31'b0, s_ov});
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        chk("bp_no_extra", {31'b0, out_valid}, 32'd0);

        // Async reset mid-frame (after 2 of 3 words)
        send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_frame_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_frame_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Async reset while a result is pending
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_res_ready", {31'b0, in_ready},  32'd1);
        chk("arst_res_count", 32'(out_count),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_no_pulse", {31'b0, out_valid}, 32'd0);

        send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        take("post_rst", 1'b1, 1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
